// File: rtl/ones_frame_accumulator.sv
// rtl/ones_frame_accumulator.sv - frame-level accumulator for the 15-input ones counter
//
// Purpose:
//   Sums the 4-bit ones counts of up to FRAME_LEN accepted words into one frame
//   total. The total, the word count, a threshold flag and a sticky overflow flag
//   are then presented with a valid/ready handshake. Frames do not overlap: a new
//   frame is accepted at the earliest one cycle after the previous result is taken.
//
// Build option:
//   ONES_ACC_SATURATE_EN - when defined, the accumulator clamps at 2^ACC_W-1
//                          instead of wrapping modulo 2^ACC_W.
//
// Parameters:
//   FRAME_LEN  maximum words per frame (2..255)
//   ACC_W      accumulator / result width (>= 4)
//   THRESH     total at or above which out_above is set
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_valid   cnt_in / in_last valid this cycle
//   in_ready   block can accept a word
//   cnt_in     ones count of one 15-bit word (0..15)
//   in_last    accepted word closes the frame early
//   out_valid  frame result valid
//   out_ready  consumer takes the result
//   acc_out    frame total
//   word_cnt   number of words in the reported frame
//   out_above  acc_out >= THRESH
//   overflow   total exceeded 2^ACC_W-1 during the frame

module ones_frame_accumulator #(
    parameter int FRAME_LEN = 16,
    parameter int ACC_W     = 8,
    parameter int THRESH    = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cnt_in,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       word_cnt,
    output logic             out_above,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Running frame state
    logic [ACC_W-1:0] acc_q;
    logic [7:0]       idx_q;
    logic             ovf_q;

    // Registered frame result, held after consume until the next frame closes
    logic [ACC_W-1:0] acc_out_q;
    logic [7:0]       word_cnt_q;
    logic             above_q;
    logic             ovf_out_q;

    // Datapath next values
    logic             xfer;
    logic             consume;
    logic [ACC_W-1:0] cnt_ext;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_full;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic [7:0]       idx_next;
    logic             close_frame;
    logic             above_next;

    assign xfer    = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Accumulation datapath
    // ------------------------------------------------------------------
    always_comb begin
        cnt_ext  = {{(ACC_W-4){1'b0}}, cnt_in};
        // The first word of a frame starts from zero rather than the stale
        // accumulator, so the frame start also clears the sticky overflow.
        acc_base = (state_q == S_IDLE) ? '0 : acc_q;
        sum_full = {1'b0, acc_base} + {1'b0, cnt_ext};
        carry    = sum_full[ACC_W];
`ifdef ONES_ACC_SATURATE_EN
        acc_next = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
        acc_next = sum_full[ACC_W-1:0];
`endif
        ovf_next = carry | ((state_q == S_IDLE) ? 1'b0 : ovf_q);
        idx_next = (state_q == S_IDLE) ? 8'd1 : idx_q + 8'd1;
        // idx_next == 1 in IDLE can never equal FRAME_LEN (>= 2), so the
        // length cap only closes frames from ACCUM.
        close_frame = in_last || (idx_next == 8'(FRAME_LEN));
        // THRESH may lie outside the ACC_W range, so compare at 32 bits.
        above_next  = (32'(acc_next) >= 32'(THRESH));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d = close_frame ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (xfer && close_frame) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // in_ready is masked by rst so the reset cycle never accepts a word.
        in_ready  = !rst && (state_q == S_IDLE || state_q == S_ACCUM);
        out_valid = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Frame accumulator and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            acc_out_q  <= '0;
            word_cnt_q <= '0;
            above_q    <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            if (xfer) begin
                acc_q <= acc_next;
                idx_q <= idx_next;
                ovf_q <= ovf_next;
                if (close_frame) begin
                    acc_out_q  <= acc_next;
                    word_cnt_q <= idx_next;
                    above_q    <= above_next;
                    ovf_out_q  <= ovf_next;
                end
            end
            if (consume) begin
                acc_q <= '0;
                idx_q <= '0;
                ovf_q <= 1'b0;
            end
        end
    end

    assign acc_out   = acc_out_q;
    assign word_cnt  = word_cnt_q;
    assign out_above = above_q;
    assign overflow  = ovf_out_q;

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// tb/tb_ones_frame_accumulator.sv - self-checking bench for ones_frame_accumulator

module tb_ones_frame_accumulator;

    localparam int FL = 16;
    localparam int AW = 8;
    localparam int TH = 120;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [3:0]    cnt_in;
    logic          out_valid, out_ready, out_above, overflow;
    logic [AW-1:0] acc_out;
    logic [7:0]    word_cnt;

    logic          s_in_valid, s_in_ready, s_in_last;
    logic [3:0]    s_cnt_in;
    logic          s_out_valid, s_out_ready, s_out_above, s_overflow;
    logic [5:0]    s_acc_out;
    logic [7:0]    s_word_cnt;

    int checks   = 0;
    int failures = 0;

    int q_cnt[$];
    bit q_last[$];

    ones_frame_accumulator #(.FRAME_LEN(FL), .ACC_W(AW), .THRESH(TH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .cnt_in(cnt_in), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .word_cnt(word_cnt), .out_above(out_above), .overflow(overflow)
    );

    ones_frame_accumulator #(.FRAME_LEN(8), .ACC_W(6), .THRESH(120)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .cnt_in(s_cnt_in), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .acc_out(s_acc_out),
        .word_cnt(s_word_cnt), .out_above(s_out_above), .overflow(s_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected total of a frame whose exact (unbounded) sum is 'sum'.
    function automatic int unsigned model_acc(input int unsigned sum, input int w);
        int unsigned m;
        m = (32'd1 << w) - 1;
`ifdef ONES_ACC_SATURATE_EN
        return (sum > m) ? m : sum;
`else
        return sum & m;
`endif
    endfunction

    // Sends the frame held in q_cnt/q_last and checks the result against the model.
    // Entered and left on a falling edge.
    task automatic run_frame(input string tag, input bit gaps, input int hold);
        int unsigned sum;
        int unsigned exp_acc;
        int k;
        int wait_n;
        sum = 0;
        k = 0;
        while (k < q_cnt.size()) begin
            sum += q_cnt[k];
            k++;
            if (q_last[k-1] || k == FL) break;
        end
        exp_acc = model_acc(sum, AW);

        for (int i = 0; i < k; i++) begin
            in_valid = 1'b1;
            cnt_in   = 4'(q_cnt[i]);
            in_last  = q_last[i];
            wait_n = 0;
            while (!in_ready && wait_n < 20) begin
                @(negedge clk);
                wait_n++;
            end
            chk({tag, " in_ready_open"}, 32'(in_ready), 32'd1);
            chk({tag, " no_early_valid"}, 32'(out_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            if (gaps && i < k - 1) begin
                in_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " acc_out"},   32'(acc_out),   exp_acc);
        chk({tag, " word_cnt"},  32'(word_cnt),  32'(k));
        chk({tag, " out_above"}, 32'(out_above), 32'(exp_acc >= TH));
        chk({tag, " overflow"},  32'(overflow),  32'(sum > 255));
        chk({tag, " in_ready_closed"}, 32'(in_ready), 32'd0);

        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, " hold_acc"},   32'(acc_out),   exp_acc);
                chk({tag, " hold_wc"},    32'(word_cnt),  32'(k));
                chk({tag, " hold_ready"}, 32'(in_ready),  32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " consumed_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " consumed_ready"}, 32'(in_ready),  32'd1);
        chk({tag, " kept_acc"},       32'(acc_out),   exp_acc);
        chk({tag, " kept_wc"},        32'(word_cnt),  32'(k));
    endtask

    initial begin
        int len;
        rst = 1'b1;
        in_valid = 1'b0; cnt_in = 4'd0; in_last = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_cnt_in = 4'd0; s_in_last = 1'b0; s_out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready",  32'(in_ready),  32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst acc_out",   32'(acc_out),   32'd0);
        chk("rst word_cnt",  32'(word_cnt),  32'd0);
        chk("rst out_above", 32'(out_above), 32'd0);
        chk("rst overflow",  32'(overflow),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

        // 16 x 15, no in_last, out_ready held
        q_cnt.delete(); q_last.delete();
        for (int i = 0; i < 16; i++) begin q_cnt.push_back(15); q_last.push_back(1'b0); end
        run_frame("full15", 1'b0, 0);

        // 3,5,7 with in_last, held 5 cycles before consume
        q_cnt = '{3, 5, 7}; q_last = '{1'b0, 1'b0, 1'b1};
        run_frame("short357", 1'b0, 5);

        // Single-word frame
        q_cnt = '{9}; q_last = '{1'b1};
        run_frame("one_word", 1'b0, 1);

        // Zero counts still count as words
        q_cnt = '{0, 0, 0, 0}; q_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        run_frame("zeros", 1'b0, 0);

        // in_last coinciding with the FRAME_LEN-th word
        q_cnt.delete(); q_last.delete();
        for (int i = 0; i < 16; i++) begin q_cnt.push_back(i); q_last.push_back(i == 15); end
        run_frame("last_at_cap", 1'b0, 2);

        // Valid every other cycle, 16 x 8
        q_cnt.delete(); q_last.delete();
        for (int i = 0; i < 16; i++) begin q_cnt.push_back(8); q_last.push_back(1'b0); end
        run_frame("gaps8", 1'b1, 0);

        // Narrow instance: 8 x 15 into 6 bits
        s_in_valid = 1'b1; s_cnt_in = 4'd15;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        chk("small out_valid", 32'(s_out_valid), 32'd1);
        chk("small acc_out",   32'(s_acc_out),   model_acc(120, 6));
        chk("small word_cnt",  32'(s_word_cnt),  32'd8);
        chk("small overflow",  32'(s_overflow),  32'd1);
        chk("small out_above", 32'(s_out_above), 32'd0);
        chk("small in_ready",  32'(s_in_ready),  32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("small consumed", 32'(s_out_valid), 32'd0);

        // Reset after 4 words of 10: partial frame discarded
        in_valid = 1'b1; cnt_in = 4'd10; in_last = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready",  32'(in_ready),  32'd0);
        chk("midrst acc_out",   32'(acc_out),   32'd0);
        chk("midrst word_cnt",  32'(word_cnt),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst no_result", 32'(out_valid), 32'd0);
        q_cnt = '{1, 2}; q_last = '{1'b0, 1'b1};
        run_frame("after_rst", 1'b0, 0);

        // Reset while a result is pending
        out_ready = 1'b0;
        in_valid = 1'b1; cnt_in = 4'd9; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        chk("donerst pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("donerst out_valid", 32'(out_valid), 32'd0);
        chk("donerst acc_out",   32'(acc_out),   32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("donerst idle_valid", 32'(out_valid), 32'd0);
        chk("donerst idle_ready", 32'(in_ready),  32'd1);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            q_cnt.delete(); q_last.delete();
            len = $urandom_range(1, 20);
            for (int j = 0; j < len; j++) begin
                q_cnt.push_back($urandom_range(0, 15));
                q_last.push_back(1'b0);
            end
            if ($urandom_range(0, 1) == 1) begin
                q_last[len-1] = 1'b1;
            end else begin
                while (q_cnt.size() < FL) begin
                    q_cnt.push_back($urandom_range(0, 15));
                    q_last.push_back(1'b0);
                end
            end
            run_frame("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
